// File: rtl/fetch_unit_pkg.sv
// Shared core constants and fetch-stage types; also consumed by decode and the hazard unit.
package fetch_unit_pkg;

  localparam int          CORE_XLEN     = 32;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] CORE_NOP      = 32'h0000_0013;

  // Per-cycle fetch action, resolved from the hazard controls with flush > stall > run.
  typedef enum logic [1:0] {
    FOP_RUN   = 2'd0,
    FOP_STALL = 2'd1,
    FOP_FLUSH = 2'd2
  } fetchOp_e;

  typedef struct packed {
    logic                 valid;
    logic [CORE_XLEN-1:0] pc;
    logic [31:0]          instr;
  } f2Out_t;

  function automatic fetchOp_e decodeOp(input logic stall, input logic flush);
    if (flush)      return FOP_FLUSH;
    else if (stall) return FOP_STALL;
    else            return FOP_RUN;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard controls in, IMEM read port, and the F2 view handed to Decode.
interface fetch_unit_if import fetch_unit_pkg::*; #(
  parameter int XLEN = CORE_XLEN
) ();

  logic            stallF;
  logic            flushF2;
  logic [XLEN-1:0] redirectPc;
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic [31:0]     imemRdata;
  logic [31:0]     instrF2;
  logic [XLEN-1:0] pcF2;
  logic [XLEN-1:0] pcPlus4F2;
  logic            validF2;

  modport master (
    input  stallF, flushF2, redirectPc, imemRdata,
    output imemReq, imemAddr, instrF2, pcF2, pcPlus4F2, validF2
  );

  modport slave (
    output stallF, flushF2, redirectPc, imemRdata,
    input  imemReq, imemAddr, instrF2, pcF2, pcPlus4F2, validF2
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry capture/replay register holding the F2 instruction across multi-cycle stalls.
module fetch_hold_buf import fetch_unit_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         capture,
  input  logic         releaseEn,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  // Only the first stall cycle captures: later IMEM data belongs to pcF1, not pcF2.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture && !valid) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (releaseEn) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-stage instruction fetch: F1 issues the IMEM address, F2 presents {instr, pc, valid} to Decode.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int              XLEN      = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = CORE_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = CORE_NOP
) (
  input logic         clk,
  input logic         rstN,
  fetch_unit_if.master bus
);

  logic [XLEN-1:0] pcF1;
  logic [XLEN-1:0] pcF2;
  logic            validF2;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fetchAddr;
  logic [31:0]     holdInstr;
  logic            holdValid;
  fetchOp_e        op;

  assign op        = decodeOp(bus.stallF, bus.flushF2);
  assign target    = {bus.redirectPc[XLEN-1:2], 2'b00};
  // Redirect target goes to IMEM in the flush cycle itself, so the only penalty is the killed F2.
  assign fetchAddr = (op == FOP_FLUSH) ? target : pcF1;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      pcF1    <= RESET_PC;
      pcF2    <= RESET_PC;
      validF2 <= 1'b0;
    end else begin
      case (op)
        FOP_STALL: begin
          pcF1    <= pcF1;
          pcF2    <= pcF2;
          validF2 <= validF2;
        end
        default: begin
          pcF2    <= fetchAddr;
          pcF1    <= fetchAddr + XLEN'(4);
          validF2 <= 1'b1;
        end
      endcase
    end
  end

  fetch_hold_buf #(.W(32)) u_hold (
    .clk       (clk),
    .rstN      (rstN),
    .capture   (op == FOP_STALL),
    .releaseEn (op == FOP_RUN),
    .clear     (op == FOP_FLUSH),
    .din       (bus.imemRdata),
    .dout      (holdInstr),
    .valid     (holdValid)
  );

  assign bus.imemReq   = 1'b1;
  assign bus.imemAddr  = fetchAddr;
  assign bus.instrF2   = !validF2 ? NOP_INSTR : (holdValid ? holdInstr : bus.imemRdata);
  assign bus.pcF2      = pcF2;
  assign bus.pcPlus4F2 = pcF2 + XLEN'(4);
  assign bus.validF2   = validF2;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against an architectural next-PC model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // IMEM: mem[i] = i, one-cycle registered read.
  always @(posedge clk) if (bus.imemReq) bus.imemRdata <= {2'b00, bus.imemAddr[31:2]};

  int nChecks = 0;
  int nFails  = 0;

  // Architectural model: address of the instruction Decode sees, and the next sequential address.
  logic [31:0] mNext, mPc;
  logic        mValid;

  function automatic logic [31:0] expInstr();
    return mValid ? {2'b00, mPc[31:2]} : NOP;
  endfunction

  function automatic logic [31:0] expAddr();
    return bus.flushF2 ? {bus.redirectPc[31:2], 2'b00} : mNext;
  endfunction

  task automatic setIn(input logic r, input logic st, input logic fl, input logic [31:0] tgt);
    rstN = r; bus.stallF = st; bus.flushF2 = fl; bus.redirectPc = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstN) begin
      mNext = 32'h0; mPc = 32'h0; mValid = 1'b0;
    end else if (bus.flushF2) begin
      mPc = {bus.redirectPc[31:2], 2'b00}; mNext = mPc + 32'd4; mValid = 1'b1;
    end else if (!bus.stallF) begin
      mPc = mNext; mNext = mNext + 32'd4; mValid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    setIn(0, 0, 0, 32'h0); tick(); tick();
    nChecks++; if (bus.validF2 !== 1'b0) begin nFails++; $display("FAIL reset_valid got=%b exp=0", bus.validF2); end
    nChecks++; if (bus.instrF2 !== NOP) begin nFails++; $display("FAIL reset_instr got=%h exp=%h", bus.instrF2, NOP); end
    nChecks++; if (bus.imemAddr !== 32'h0) begin nFails++; $display("FAIL reset_addr got=%h exp=0", bus.imemAddr); end
    nChecks++; if (bus.imemReq !== 1'b1) begin nFails++; $display("FAIL reset_req got=%b exp=1", bus.imemReq); end
  endtask

  task automatic test_fetch_seq();
    setIn(1, 0, 0, 32'h0);
    nChecks++; if (bus.validF2 !== 1'b0) begin nFails++; $display("FAIL seq_prevalid got=%b exp=0", bus.validF2); end
    nChecks++; if (bus.imemAddr !== 32'h0) begin nFails++; $display("FAIL seq_addr0 got=%h exp=0", bus.imemAddr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (bus.validF2 !== 1'b1) begin nFails++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, bus.validF2); end
      nChecks++; if (bus.pcF2 !== 32'(4*i)) begin nFails++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pcF2, 32'(4*i)); end
      nChecks++; if (bus.instrF2 !== 32'(i)) begin nFails++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.instrF2, 32'(i)); end
      nChecks++; if (bus.imemAddr !== 32'(4*i+4)) begin nFails++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, bus.imemAddr, 32'(4*i+4)); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++) begin
      setIn(1, (k < 3), 0, 32'h0);
      nChecks++; if (bus.instrF2 !== 32'd2) begin nFails++; $display("FAIL stall_instr[%0d] got=%h exp=2", k, bus.instrF2); end
      nChecks++; if (bus.pcF2 !== 32'd8) begin nFails++; $display("FAIL stall_pc[%0d] got=%h exp=8", k, bus.pcF2); end
      nChecks++; if (bus.imemAddr !== 32'd12) begin nFails++; $display("FAIL stall_addr[%0d] got=%h exp=c", k, bus.imemAddr); end
      tick();
    end
    nChecks++; if (bus.instrF2 !== 32'd3) begin nFails++; $display("FAIL stall_next_instr got=%h exp=3", bus.instrF2); end
    nChecks++; if (bus.pcF2 !== 32'd12) begin nFails++; $display("FAIL stall_next_pc got=%h exp=c", bus.pcF2); end
    tick();
  endtask

  task automatic test_flush();
    setIn(1, 0, 1, 32'h100);
    nChecks++; if (bus.pcF2 !== 32'h10) begin nFails++; $display("FAIL flush_pre_pc got=%h exp=10", bus.pcF2); end
    nChecks++; if (bus.imemAddr !== 32'h100) begin nFails++; $display("FAIL flush_addr got=%h exp=100", bus.imemAddr); end
    tick(); setIn(1, 0, 0, 32'h0);
    nChecks++; if (bus.pcF2 !== 32'h100) begin nFails++; $display("FAIL flush_pc got=%h exp=100", bus.pcF2); end
    nChecks++; if (bus.instrF2 !== 32'h40) begin nFails++; $display("FAIL flush_instr got=%h exp=40", bus.instrF2); end
    nChecks++; if (bus.pcPlus4F2 !== 32'h104) begin nFails++; $display("FAIL flush_pc4 got=%h exp=104", bus.pcPlus4F2); end
    tick();
  endtask

  task automatic test_stall_flush();
    setIn(1, 1, 0, 32'h0); tick(); tick();
    setIn(1, 1, 1, 32'h200);
    nChecks++; if (bus.imemAddr !== 32'h200) begin nFails++; $display("FAIL sf_addr got=%h exp=200", bus.imemAddr); end
    tick(); setIn(1, 0, 0, 32'h0);
    nChecks++; if (bus.pcF2 !== 32'h200) begin nFails++; $display("FAIL sf_pc got=%h exp=200", bus.pcF2); end
    nChecks++; if (bus.instrF2 !== 32'h80) begin nFails++; $display("FAIL sf_instr got=%h exp=80", bus.instrF2); end
    tick();
    nChecks++; if (bus.instrF2 !== 32'h81) begin nFails++; $display("FAIL sf_next_instr got=%h exp=81", bus.instrF2); end
  endtask

  task automatic test_misalign_wrap();
    logic [31:0] p;
    setIn(1, 0, 1, 32'h103);
    nChecks++; if (bus.imemAddr !== 32'h100) begin nFails++; $display("FAIL mis_addr got=%h exp=100", bus.imemAddr); end
    tick(); setIn(1, 0, 0, 32'h0);
    nChecks++; if (bus.pcF2 !== 32'h100) begin nFails++; $display("FAIL mis_pc got=%h exp=100", bus.pcF2); end
    setIn(1, 0, 1, 32'hFFFF_FFF8); tick(); setIn(1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      p = 32'hFFFF_FFF8 + 32'(4*i);
      nChecks++; if (bus.pcF2 !== p) begin nFails++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, bus.pcF2, p); end
      nChecks++; if (bus.instrF2 !== {2'b00, p[31:2]}) begin nFails++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", i, bus.instrF2, {2'b00, p[31:2]}); end
      nChecks++; if (bus.pcPlus4F2 !== p + 32'd4) begin nFails++; $display("FAIL wrap_pc4[%0d] got=%h exp=%h", i, bus.pcPlus4F2, p + 32'd4); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    setIn(1, 1, 0, 32'h0); tick(); tick();
    setIn(0, 1, 0, 32'h0); tick();
    nChecks++; if (bus.validF2 !== 1'b0) begin nFails++; $display("FAIL rst_stall_valid got=%b exp=0", bus.validF2); end
    nChecks++; if (bus.instrF2 !== NOP) begin nFails++; $display("FAIL rst_stall_instr got=%h exp=%h", bus.instrF2, NOP); end
    nChecks++; if (bus.imemAddr !== 32'h0) begin nFails++; $display("FAIL rst_stall_addr got=%h exp=0", bus.imemAddr); end
    setIn(1, 0, 0, 32'h0); tick();
    nChecks++; if (bus.pcF2 !== 32'h0 || bus.instrF2 !== 32'h0 || bus.validF2 !== 1'b1) begin
      nFails++; $display("FAIL rst_stall_first got pc=%h instr=%h v=%b exp pc=0 instr=0 v=1", bus.pcF2, bus.instrF2, bus.validF2);
    end
  endtask

  task automatic test_back_to_back();
    setIn(1, 0, 1, 32'h300); tick();
    setIn(1, 0, 1, 32'h400);
    nChecks++; if (bus.imemAddr !== 32'h400) begin nFails++; $display("FAIL b2b_addr got=%h exp=400", bus.imemAddr); end
    tick(); setIn(1, 0, 0, 32'h0);
    nChecks++; if (bus.pcF2 !== 32'h400) begin nFails++; $display("FAIL b2b_pc got=%h exp=400", bus.pcF2); end
    nChecks++; if (bus.instrF2 !== 32'h100) begin nFails++; $display("FAIL b2b_instr got=%h exp=100", bus.instrF2); end
    tick();
    nChecks++; if (bus.pcF2 !== 32'h404) begin nFails++; $display("FAIL b2b_next_pc got=%h exp=404", bus.pcF2); end
  endtask

  task automatic test_random();
    logic r, st, fl;
    for (int c = 0; c < 500; c++) begin
      r  = ($urandom_range(99) >= 2);
      st = ($urandom_range(99) < 35);
      fl = ($urandom_range(99) < 15);
      setIn(r, st, fl, $urandom);
      nChecks++; if (bus.imemAddr !== expAddr()) begin nFails++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", c, bus.imemAddr, expAddr()); end
      nChecks++; if (bus.validF2 !== mValid) begin nFails++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, bus.validF2, mValid); end
      nChecks++; if (bus.instrF2 !== expInstr()) begin nFails++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", c, bus.instrF2, expInstr()); end
      if (mValid) begin
        nChecks++; if (bus.pcF2 !== mPc) begin nFails++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", c, bus.pcF2, mPc); end
        nChecks++; if (bus.pcPlus4F2 !== mPc + 32'd4) begin nFails++; $display("FAIL rnd_pc4[%0d] got=%h exp=%h", c, bus.pcPlus4F2, mPc + 32'd4); end
      end
      tick();
    end
  endtask

  initial begin
    bus.stallF = 1'b0; bus.flushF2 = 1'b0; bus.redirectPc = 32'h0;
    test_reset();
    test_fetch_seq();
    test_stall();
    test_flush();
    test_stall_flush();
    test_misalign_wrap();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
